// File: rtl/mpu_store_receiver_pkg.sv
// Shared types and sizing for the mpu_store element-stream receiver.
// Optional feature macro used by this slice: MPU_STORE_RX_NAN_CHECK_EN.
package mpu_store_receiver_pkg;

    // Element and matrix sizing
    localparam int unsigned FP           = 32;
    localparam int unsigned M            = 4;
    localparam int unsigned N            = 4;
    localparam int unsigned MBITS        = 2;
    localparam int unsigned NBITS        = 2;
    localparam int unsigned NUM_ELEMENTS = M * N;
    localparam int unsigned BUF_DEPTH    = NUM_ELEMENTS;
    localparam int unsigned ABITS        = $clog2(BUF_DEPTH);

    // All-ones exponent of an IEEE-754 single (Inf/NaN class)
    localparam logic [7:0] NAN_EXP = 8'hFF;

    typedef enum logic [1:0] {
        StIdle,
        StCapture,
        StDone
    } store_rx_state_t;

    // Quiet or signalling NaN: exponent all ones with a non-zero mantissa
    function automatic logic is_nan(input logic [FP-1:0] elem);
        return (elem[30:23] == NAN_EXP) && (elem[22:0] != '0);
    endfunction

endpackage

// File: rtl/mpu_store_receiver_if.sv
// Element-stream, readback and status bundle of the store receiver.
// nan_flag_out exists only when MPU_STORE_RX_NAN_CHECK_EN is defined.
interface mpu_store_receiver_if;
    import mpu_store_receiver_pkg::*;

    logic             mem_store_en_in;
    logic [FP-1:0]    mem_store_element_in;
    logic [MBITS:0]   mem_m_store_size_in;
    logic [NBITS:0]   mem_n_store_size_in;
    logic             rd_en_in;
    logic [ABITS-1:0] rd_addr_in;
    logic [FP-1:0]    rd_element_out;
    logic             rd_valid_out;
    logic             store_busy_out;
    logic             store_done_out;
    logic             store_error_out;
    logic [MBITS:0]   store_m_out;
    logic [NBITS:0]   store_n_out;
    logic [ABITS:0]   store_count_out;
`ifdef MPU_STORE_RX_NAN_CHECK_EN
    logic             nan_flag_out;
`endif

    // Producer / host side
    modport master (
        output mem_store_en_in, mem_store_element_in, mem_m_store_size_in,
               mem_n_store_size_in, rd_en_in, rd_addr_in,
        input  rd_element_out, rd_valid_out, store_busy_out, store_done_out,
               store_error_out, store_m_out, store_n_out, store_count_out
`ifdef MPU_STORE_RX_NAN_CHECK_EN
        , input nan_flag_out
`endif
    );

    // Receiver side
    modport slave (
        input  mem_store_en_in, mem_store_element_in, mem_m_store_size_in,
               mem_n_store_size_in, rd_en_in, rd_addr_in,
        output rd_element_out, rd_valid_out, store_busy_out, store_done_out,
               store_error_out, store_m_out, store_n_out, store_count_out
`ifdef MPU_STORE_RX_NAN_CHECK_EN
        , output nan_flag_out
`endif
    );

endinterface

// File: rtl/mpu_store_receiver_buffer.sv
// Element RAM for the store receiver: one write port, one registered read port.
// Reset clears every entry so a reset discards any partially captured matrix.
module mpu_store_receiver_buffer
    import mpu_store_receiver_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [ABITS-1:0] wr_addr,
    input  logic [FP-1:0]    wr_data,
    input  logic             rd_en,
    input  logic [ABITS-1:0] rd_addr,
    input  logic             rd_zero,
    output logic [FP-1:0]    rd_data
);

    logic [FP-1:0] mem_q [BUF_DEPTH];
    logic [FP-1:0] rd_data_q;

    // Storage and read register; the read samples the pre-write contents
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(BUF_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            rd_data_q <= '0;
        end else begin
            if (wr_en) begin
                mem_q[wr_addr] <= wr_data;
            end
            if (rd_en) begin
                rd_data_q <= rd_zero ? '0 : mem_q[rd_addr];
            end
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/mpu_store_receiver.sv
// Memory-side receiver for the mpu_store element stream: captures one row-major
// matrix per transfer, records its size and reports done/error status.
// Optional: MPU_STORE_RX_NAN_CHECK_EN adds a sticky NaN flag output.
module mpu_store_receiver
    import mpu_store_receiver_pkg::*;
(
    input logic                 clk,
    input logic                 rst,
    mpu_store_receiver_if.slave bus
);

    store_rx_state_t state;
    logic [MBITS:0]  m_q;
    logic [NBITS:0]  n_q;
    logic [ABITS:0]  count_q;
    logic            busy_q;
    logic            done_q;
    logic            error_q;
    logic            rd_valid_q;
`ifdef MPU_STORE_RX_NAN_CHECK_EN
    logic            nan_q;
`endif

    logic [ABITS:0]   in_total;
    logic [ABITS:0]   cur_total;
    logic [ABITS:0]   count_next;
    logic             size_bad;
    logic             size_mismatch;
    logic             first_ok;
    logic             cap_ok;
    logic             wr_en;
    logic [ABITS-1:0] wr_addr;
    logic             rd_zero;
    logic [FP-1:0]    rd_data;

    assign in_total   = (ABITS+1)'(bus.mem_m_store_size_in) * (ABITS+1)'(bus.mem_n_store_size_in);
    assign cur_total  = (ABITS+1)'(m_q) * (ABITS+1)'(n_q);
    assign count_next = count_q + 1'b1;

    assign size_bad = (bus.mem_m_store_size_in == '0) || (bus.mem_n_store_size_in == '0) ||
                      (32'(bus.mem_m_store_size_in) > M) || (32'(bus.mem_n_store_size_in) > N);
    assign size_mismatch = (bus.mem_m_store_size_in != m_q) || (bus.mem_n_store_size_in != n_q);

    // A beat in DONE starts a new transfer, exactly as in IDLE
    assign first_ok = bus.mem_store_en_in && (state != StCapture) && !size_bad;
    assign cap_ok   = bus.mem_store_en_in && (state == StCapture) && !size_mismatch;
    assign wr_en    = first_ok || cap_ok;
    assign wr_addr  = (state == StCapture) ? count_q[ABITS-1:0] : '0;

    // Accepted sizes never exceed BUF_DEPTH, so the m*n bound covers the depth bound too
    assign rd_zero = {1'b0, bus.rd_addr_in} >= cur_total;

    mpu_store_receiver_buffer u_buffer (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (bus.mem_store_element_in),
        .rd_en   (bus.rd_en_in),
        .rd_addr (bus.rd_addr_in),
        .rd_zero (rd_zero),
        .rd_data (rd_data)
    );

    // Transfer FSM with registered status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= StIdle;
            m_q     <= '0;
            n_q     <= '0;
            count_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
`ifdef MPU_STORE_RX_NAN_CHECK_EN
            nan_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state)
                StIdle, StDone: begin
                    state  <= StIdle;
                    busy_q <= 1'b0;
                    if (bus.mem_store_en_in) begin
                        if (size_bad) begin
                            // Rejected first beat leaves size, count and buffer untouched
                            error_q <= 1'b1;
                        end else begin
                            m_q     <= bus.mem_m_store_size_in;
                            n_q     <= bus.mem_n_store_size_in;
                            count_q <= (ABITS+1)'(1);
                            error_q <= 1'b0;
`ifdef MPU_STORE_RX_NAN_CHECK_EN
                            nan_q   <= is_nan(bus.mem_store_element_in);
`endif
                            if (in_total == (ABITS+1)'(1)) begin
                                state  <= StDone;
                                done_q <= 1'b1;
                            end else begin
                                state  <= StCapture;
                                busy_q <= 1'b1;
                            end
                        end
                    end
                end
                StCapture: begin
                    if (bus.mem_store_en_in) begin
                        if (size_mismatch) begin
                            // Abort: beat dropped, count keeps the accepted total
                            error_q <= 1'b1;
                            state   <= StIdle;
                            busy_q  <= 1'b0;
                        end else begin
                            count_q <= count_next;
`ifdef MPU_STORE_RX_NAN_CHECK_EN
                            nan_q   <= nan_q | is_nan(bus.mem_store_element_in);
`endif
                            if (count_next == cur_total) begin
                                state  <= StDone;
                                done_q <= 1'b1;
                                busy_q <= 1'b0;
                            end
                        end
                    end
                end
                default: begin
                    state  <= StIdle;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    // Readback valid follows the request by one cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= bus.rd_en_in;
        end
    end

    assign bus.rd_element_out  = rd_data;
    assign bus.rd_valid_out    = rd_valid_q;
    assign bus.store_busy_out  = busy_q;
    assign bus.store_done_out  = done_q;
    assign bus.store_error_out = error_q;
    assign bus.store_m_out     = m_q;
    assign bus.store_n_out     = n_q;
    assign bus.store_count_out = count_q;
`ifdef MPU_STORE_RX_NAN_CHECK_EN
    assign bus.nan_flag_out    = nan_q;
`endif

endmodule

// File: tb/tb_mpu_store_receiver.sv
// Self-checking bench for mpu_store_receiver; expected buffer contents come from a
// transfer-level array model (written entries, accepted m/n) kept in the bench.
module tb_mpu_store_receiver;
    import mpu_store_receiver_pkg::*;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   done_cnt;

    // Reference model: buffer image and last accepted size
    logic [31:0] ref_mem [16];
    int          ref_m;
    int          ref_n;

    logic [31:0] words3 [9] = '{32'h3f800000, 32'h424951ec, 32'hc0200000, 32'h3e000000,
                                32'hbeaaaa9f, 32'h4e932c06, 32'h00000000, 32'hb6a7c5ac,
                                32'hd0132c06};

    mpu_store_receiver_if bus ();

    mpu_store_receiver dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.store_done_out === 1'b1) done_cnt++;
    end

    task automatic drive_beat(input logic [31:0] d, input int m, input int n);
        bus.mem_store_en_in      = 1'b1;
        bus.mem_store_element_in = d;
        bus.mem_m_store_size_in  = (MBITS+1)'(m);
        bus.mem_n_store_size_in  = (NBITS+1)'(n);
        @(posedge clk);
        #1;
        bus.mem_store_en_in = 1'b0;
    endtask

    task automatic idle_cycles(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic read_word(input int addr, output logic [31:0] d, output logic v);
        bus.rd_en_in   = 1'b1;
        bus.rd_addr_in = ABITS'(addr);
        @(posedge clk);
        #1;
        d = bus.rd_element_out;
        v = bus.rd_valid_out;
        bus.rd_en_in = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic        v;
        total++;
        if (bus.store_busy_out !== 1'b0 || bus.store_done_out !== 1'b0 ||
            bus.store_error_out !== 1'b0 || bus.rd_valid_out !== 1'b0) begin
            bad++;
            $display("FAIL reset_flags: busy=%b done=%b err=%b rdv=%b required all 0",
                     bus.store_busy_out, bus.store_done_out, bus.store_error_out,
                     bus.rd_valid_out);
        end
        total++;
        if (bus.store_m_out !== '0 || bus.store_n_out !== '0 || bus.store_count_out !== '0 ||
            bus.rd_element_out !== '0) begin
            bad++;
            $display("FAIL reset_values: m=%0d n=%0d count=%0d rd=%h required 0",
                     bus.store_m_out, bus.store_n_out, bus.store_count_out, bus.rd_element_out);
        end
        read_word(0, d, v);
        total++;
        if (d !== 32'h0 || v !== 1'b1) begin
            bad++;
            $display("FAIL reset_read0: data=%h valid=%b required 00000000/1", d, v);
        end
        total++;
        idle_cycles(1);
        if (bus.rd_valid_out !== 1'b0) begin
            bad++;
            $display("FAIL rd_valid_pulse: valid=%b required 0", bus.rd_valid_out);
        end
    endtask

    task automatic test_stream_3x3();
        logic [31:0] d;
        logic        v;
        done_cnt = 0;
        for (int i = 0; i < 9; i++) begin
            drive_beat(words3[i], 3, 3);
            total++;
            if (bus.store_done_out !== (i == 8) || bus.store_busy_out !== (i < 8)) begin
                bad++;
                $display("FAIL stream_beat%0d: done=%b busy=%b required %b/%b", i,
                         bus.store_done_out, bus.store_busy_out, i == 8, i < 8);
            end
        end
        for (int i = 0; i < 9; i++) ref_mem[i] = words3[i];
        ref_m = 3;
        ref_n = 3;
        idle_cycles(2);
        total++;
        if (done_cnt != 1 || bus.store_count_out !== 5'd9 || bus.store_m_out !== 3'd3 ||
            bus.store_n_out !== 3'd3 || bus.store_error_out !== 1'b0) begin
            bad++;
            $display("FAIL stream_status: dones=%0d count=%0d m=%0d n=%0d err=%b req 1/9/3/3/0",
                     done_cnt, bus.store_count_out, bus.store_m_out, bus.store_n_out,
                     bus.store_error_out);
        end
        for (int a = 0; a < 16; a++) begin
            read_word(a, d, v);
            total++;
            if (d !== ((a < ref_m * ref_n) ? ref_mem[a] : 32'h0) || v !== 1'b1) begin
                bad++;
                $display("FAIL stream_read[%0d]: data=%h valid=%b required %h/1", a, d, v,
                         (a < ref_m * ref_n) ? ref_mem[a] : 32'h0);
            end
        end
    endtask

    task automatic test_bad_size();
        logic [31:0] d;
        logic        v;
        done_cnt = 0;
        drive_beat($urandom, 0, 3);
        total++;
        if (bus.store_error_out !== 1'b1 || bus.store_busy_out !== 1'b0) begin
            bad++;
            $display("FAIL bad_m0: err=%b busy=%b required 1/0",
                     bus.store_error_out, bus.store_busy_out);
        end
        drive_beat($urandom, M + 1, 3);
        drive_beat($urandom, 2, N + 1);
        idle_cycles(2);
        total++;
        if (bus.store_error_out !== 1'b1 || bus.store_busy_out !== 1'b0 || done_cnt != 0 ||
            bus.store_count_out !== 5'd9) begin
            bad++;
            $display("FAIL bad_oversize: err=%b busy=%b dones=%0d count=%0d required 1/0/0/9",
                     bus.store_error_out, bus.store_busy_out, done_cnt, bus.store_count_out);
        end
        for (int a = 0; a < 9; a++) begin
            read_word(a, d, v);
            total++;
            if (d !== ref_mem[a]) begin
                bad++;
                $display("FAIL bad_unchanged[%0d]: data=%h required %h", a, d, ref_mem[a]);
            end
        end
    endtask

    task automatic test_size_change();
        logic [31:0] d;
        logic        v;
        logic [31:0] nw [3];
        done_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            nw[i] = $urandom;
            drive_beat(nw[i], 3, 3);
        end
        total++;
        if (bus.store_error_out !== 1'b0 || bus.store_busy_out !== 1'b1) begin
            bad++;
            $display("FAIL chg_running: err=%b busy=%b required 0/1",
                     bus.store_error_out, bus.store_busy_out);
        end
        drive_beat($urandom, 2, 3);
        for (int i = 0; i < 3; i++) ref_mem[i] = nw[i];
        idle_cycles(2);
        total++;
        if (bus.store_error_out !== 1'b1 || bus.store_busy_out !== 1'b0 || done_cnt != 0 ||
            bus.store_count_out !== 5'd3) begin
            bad++;
            $display("FAIL chg_abort: err=%b busy=%b dones=%0d count=%0d required 1/0/0/3",
                     bus.store_error_out, bus.store_busy_out, done_cnt, bus.store_count_out);
        end
        for (int a = 0; a < 9; a++) begin
            read_word(a, d, v);
            total++;
            if (d !== ref_mem[a]) begin
                bad++;
                $display("FAIL chg_read[%0d]: data=%h required %h", a, d, ref_mem[a]);
            end
        end
    endtask

    task automatic test_gaps();
        logic [31:0] d;
        logic        v;
        done_cnt = 0;
        for (int i = 0; i < 9; i++) begin
            drive_beat(words3[i], 3, 3);
            if (i == 0) begin
                total++;
                if (bus.store_error_out !== 1'b0) begin
                    bad++;
                    $display("FAIL gap_err_clear: err=%b required 0", bus.store_error_out);
                end
            end
            if (i < 8) begin
                bus.mem_m_store_size_in = 3'd1;  // junk size with en low must be ignored
                idle_cycles(2);
            end
        end
        total++;
        if (bus.store_busy_out !== 1'b0) begin
            bad++;
            $display("FAIL gap_busy: busy=%b required 0", bus.store_busy_out);
        end
        for (int i = 0; i < 9; i++) ref_mem[i] = words3[i];
        idle_cycles(2);
        total++;
        if (done_cnt != 1 || bus.store_count_out !== 5'd9) begin
            bad++;
            $display("FAIL gap_status: dones=%0d count=%0d required 1/9",
                     done_cnt, bus.store_count_out);
        end
        for (int a = 0; a < 9; a++) begin
            read_word(a, d, v);
            total++;
            if (d !== ref_mem[a]) begin
                bad++;
                $display("FAIL gap_read[%0d]: data=%h required %h", a, d, ref_mem[a]);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] d;
        logic        v;
        logic [31:0] w;
        for (int t = 0; t < 6; t++) begin
            int m = int'($urandom_range(1, M));
            int n = int'($urandom_range(1, N));
            done_cnt = 0;
            for (int i = 0; i < m * n; i++) begin
                w = $urandom;
                ref_mem[i] = w;
                drive_beat(w, m, n);
                idle_cycles(int'($urandom_range(0, 2)));
            end
            ref_m = m;
            ref_n = n;
            idle_cycles(2);
            total++;
            if (done_cnt != 1 || bus.store_count_out !== 5'(m * n) ||
                bus.store_m_out !== 3'(m) || bus.store_n_out !== 3'(n)) begin
                bad++;
                $display("FAIL rand%0d_status: dones=%0d count=%0d m=%0d n=%0d req 1/%0d/%0d/%0d",
                         t, done_cnt, bus.store_count_out, bus.store_m_out, bus.store_n_out,
                         m * n, m, n);
            end
            for (int a = 0; a < 16; a++) begin
                read_word(a, d, v);
                total++;
                if (d !== ((a < ref_m * ref_n) ? ref_mem[a] : 32'h0) || v !== 1'b1) begin
                    bad++;
                    $display("FAIL rand%0d_read[%0d]: data=%h valid=%b required %h/1", t, a, d,
                             v, (a < ref_m * ref_n) ? ref_mem[a] : 32'h0);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        logic        v;
        logic [31:0] bw [3];
        logic [31:0] sw;
        done_cnt = 0;
        for (int i = 0; i < 4; i++) drive_beat($urandom, 2, 2);
        for (int i = 0; i < 3; i++) begin
            bw[i] = $urandom;
            drive_beat(bw[i], 1, 3);
            ref_mem[i] = bw[i];
        end
        ref_m = 1;
        ref_n = 3;
        idle_cycles(2);
        total++;
        if (done_cnt != 2 || bus.store_count_out !== 5'd3 || bus.store_m_out !== 3'd1 ||
            bus.store_n_out !== 3'd3) begin
            bad++;
            $display("FAIL b2b_status: dones=%0d count=%0d m=%0d n=%0d required 2/3/1/3",
                     done_cnt, bus.store_count_out, bus.store_m_out, bus.store_n_out);
        end
        for (int a = 0; a < 5; a++) begin
            read_word(a, d, v);
            total++;
            if (d !== ((a < ref_m * ref_n) ? ref_mem[a] : 32'h0)) begin
                bad++;
                $display("FAIL b2b_read[%0d]: data=%h required %h", a, d,
                         (a < ref_m * ref_n) ? ref_mem[a] : 32'h0);
            end
        end
        sw = $urandom;
        drive_beat(sw, 1, 1);
        ref_mem[0] = sw;
        ref_m = 1;
        ref_n = 1;
        total++;
        if (bus.store_done_out !== 1'b1 || bus.store_busy_out !== 1'b0 ||
            bus.store_count_out !== 5'd1) begin
            bad++;
            $display("FAIL single_elem: done=%b busy=%b count=%0d required 1/0/1",
                     bus.store_done_out, bus.store_busy_out, bus.store_count_out);
        end
        read_word(1, d, v);
        total++;
        if (d !== 32'h0 || v !== 1'b1) begin
            bad++;
            $display("FAIL single_oob: data=%h valid=%b required 00000000/1", d, v);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        logic        v;
        for (int i = 0; i < 5; i++) drive_beat($urandom, 4, 4);
        rst = 1'b1;
        #1;
        total++;
        if (bus.store_busy_out !== 1'b0 || bus.store_done_out !== 1'b0 ||
            bus.store_error_out !== 1'b0 || bus.store_m_out !== '0 ||
            bus.store_n_out !== '0 || bus.store_count_out !== '0) begin
            bad++;
            $display("FAIL rst_mid: busy=%b done=%b err=%b m=%0d n=%0d count=%0d required 0",
                     bus.store_busy_out, bus.store_done_out, bus.store_error_out,
                     bus.store_m_out, bus.store_n_out, bus.store_count_out);
        end
        idle_cycles(1);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) ref_mem[i] = 32'h0;
        ref_m = 0;
        ref_n = 0;
        read_word(0, d, v);
        total++;
        if (d !== 32'h0 || v !== 1'b1) begin
            bad++;
            $display("FAIL rst_mid_read0: data=%h valid=%b required 00000000/1", d, v);
        end
    endtask

`ifdef MPU_STORE_RX_NAN_CHECK_EN
    task automatic test_nan();
        drive_beat(32'h7fc00000, 1, 2);
        drive_beat(32'h3f800000, 1, 2);
        idle_cycles(3);
        total++;
        if (bus.nan_flag_out !== 1'b1) begin
            bad++;
            $display("FAIL nan_set: flag=%b required 1", bus.nan_flag_out);
        end
        drive_beat(32'h7f800000, 1, 1);
        total++;
        if (bus.nan_flag_out !== 1'b0) begin
            bad++;
            $display("FAIL nan_clear_inf: flag=%b required 0", bus.nan_flag_out);
        end
    endtask
`endif

    initial begin
        total    = 0;
        bad      = 0;
        done_cnt = 0;
        ref_m    = 0;
        ref_n    = 0;
        for (int i = 0; i < 16; i++) ref_mem[i] = 32'h0;
        rst                      = 1'b1;
        bus.mem_store_en_in      = 1'b0;
        bus.mem_store_element_in = '0;
        bus.mem_m_store_size_in  = '0;
        bus.mem_n_store_size_in  = '0;
        bus.rd_en_in             = 1'b0;
        bus.rd_addr_in           = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        test_reset();
        test_stream_3x3();
        test_bad_size();
        test_size_change();
        test_gaps();
        test_random();
        test_back_to_back();
        test_reset_mid();
`ifdef MPU_STORE_RX_NAN_CHECK_EN
        test_nan();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
